// File: rtl/ibex_register_file_scrub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ibex_register_file_scrub                                        |
// | Purpose  : Flip-flop register file for the secure Ibex core with          |
// |            NumReadPorts asynchronous read ports, one write port,          |
// |            per-register immediate erase, bitwise-logic first-cycle write  |
// |            masking and a sequential scrub engine that wipes ScrubLanes    |
// |            registers per cycle.                                           |
// | Ports    : clk_i, rst_ni (async, active-low)                              |
// |            sec_ers_i        per-register erase (bit 0 ignored)            |
// |            sec_bwlogic_first_cycle_i  accepted write stores zero          |
// |            scrub_req_i / scrub_busy_o / scrub_done_o  scrub handshake     |
// |            raddr_i / rdata_o           packed read ports                  |
// |            waddr_i / wdata_i / we_i / we_ready_o  write port              |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module ibex_register_file_scrub #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumRegs      = 32,
  parameter int unsigned NumReadPorts = 2,
  parameter int unsigned ScrubLanes   = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NumRegs-1:0]                         sec_ers_i,
  input  logic                                       sec_bwlogic_first_cycle_i,
  input  logic                                       scrub_req_i,
  output logic                                       scrub_busy_o,
  output logic                                       scrub_done_o,
  input  logic [NumReadPorts*$clog2(NumRegs)-1:0]    raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]          rdata_o,
  input  logic [$clog2(NumRegs)-1:0]                 waddr_i,
  input  logic [DataWidth-1:0]                       wdata_i,
  input  logic                                       we_i,
  output logic                                       we_ready_o
);

  localparam int unsigned AW = $clog2(NumRegs);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } scrub_state_e;

  scrub_state_e              r_state;
  scrub_state_e              w_state_next;
  // One extra bit so the pointer cannot wrap before the last-range test.
  logic [AW:0]               r_ptr;
  logic                      r_done;
  logic [DataWidth-1:0]      r_regs [NumRegs];

  logic [AW+1:0]             w_ptr_lo;
  logic [AW+1:0]             w_ptr_end;
  logic                      w_last_range;
  logic [NumRegs-1:1]        w_wipe;
  logic                      w_we_accept;
  logic [DataWidth-1:0]      w_wdata_eff;
  logic                      w_unused_ers;

  // R0 is hardwired, so its erase bit has no register to act on.
  assign w_unused_ers = sec_ers_i[0];

  assign we_ready_o   = (r_state == IDLE);
  assign scrub_busy_o = (r_state != IDLE);
  assign scrub_done_o = r_done;

  assign w_we_accept  = we_i && we_ready_o && (waddr_i != '0);
  assign w_wdata_eff  = sec_bwlogic_first_cycle_i ? '0 : wdata_i;

  // Current wipe window is [ptr, ptr+ScrubLanes); the top is clipped
  // naturally because no register index reaches NumRegs.
  assign w_ptr_lo     = (AW+2)'(r_ptr);
  assign w_ptr_end    = w_ptr_lo + (AW+2)'(ScrubLanes);
  assign w_last_range = (w_ptr_end >= (AW+2)'(NumRegs));

  always_comb begin
    w_wipe = '0;
    if (r_state == SCRUB) begin
      for (int r = 1; r < NumRegs; r++) begin
        w_wipe[r] = ((AW+2)'(r) >= w_ptr_lo) && ((AW+2)'(r) < w_ptr_end);
      end
    end
  end

  // Scrub FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Scrub FSM: next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (scrub_req_i) w_state_next = SCRUB;
      SCRUB:   if (w_last_range) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Pointer is held at 1 while idle so a new scrub always starts at R1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr  <= (AW+1)'(1);
      r_done <= 1'b0;
    end else begin
      r_done <= (w_state_next == DONE);
      if (r_state == SCRUB) begin
        r_ptr <= r_ptr + (AW+1)'(ScrubLanes);
      end else begin
        r_ptr <= (AW+1)'(1);
      end
    end
  end

  // Register array. Priority per register: erase > scrub wipe > write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NumRegs; r++) begin
        if (sec_ers_i[r] || w_wipe[r]) begin
          r_regs[r] <= '0;
        end else if (w_we_accept && (waddr_i == AW'(r))) begin
          r_regs[r] <= w_wdata_eff;
        end
      end
    end
  end

  // Combinational reads, no write bypass.
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_read_port
    assign rdata_o[p*DataWidth +: DataWidth] = r_regs[raddr_i[p*AW +: AW]];
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_register_file_scrub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ibex_register_file_scrub                                     |
// | Purpose  : Self-checking bench: a default instance (32x32, 2 ports, 1     |
// |            lane) checked against a behavioural model plus a vector table |
// |            and hand sequences, and a 16-register 4-lane 3-port instance  |
// |            checked by a hand sequence.                                   |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ibex_register_file_scrub;

  localparam int NR_A = 32;
  localparam int L_A  = 1;
  localparam int S_A  = (NR_A - 1 + L_A - 1) / L_A;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic [31:0] ers_a;
  logic        bw_a, req_a, busy_a, done_a, we_a, ready_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;

  // Instance B signals
  logic [15:0] ers_b;
  logic        bw_b, req_b, busy_b, done_b, we_b, ready_b;
  logic [11:0] raddr_b;
  logic [95:0] rdata_b;
  logic [3:0]  waddr_b;
  logic [31:0] wdata_b;

  ibex_register_file_scrub dut_a (
    .clk_i(clk), .rst_ni(rst_n), .sec_ers_i(ers_a),
    .sec_bwlogic_first_cycle_i(bw_a), .scrub_req_i(req_a),
    .scrub_busy_o(busy_a), .scrub_done_o(done_a),
    .raddr_i(raddr_a), .rdata_o(rdata_a),
    .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a), .we_ready_o(ready_a)
  );

  ibex_register_file_scrub #(
    .DataWidth(32), .NumRegs(16), .NumReadPorts(3), .ScrubLanes(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .sec_ers_i(ers_b),
    .sec_bwlogic_first_cycle_i(bw_b), .scrub_req_i(req_b),
    .scrub_busy_o(busy_b), .scrub_done_o(done_b),
    .raddr_i(raddr_b), .rdata_o(rdata_b),
    .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b), .we_ready_o(ready_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of instance A: register contents plus scrub phase
  // (0 = idle, 1..S_A = k-th wipe cycle, S_A+1 = done cycle).
  logic [31:0] m_mem [NR_A];
  int          m_phase;

  task automatic model_reset();
    for (int r = 0; r < NR_A; r++) m_mem[r] = '0;
    m_phase = 0;
  endtask

  task automatic model_edge();
    int lo, hi;
    if (m_phase == 0) begin
      if (we_a && waddr_a != 0) m_mem[waddr_a] = bw_a ? 32'h0 : wdata_a;
      if (req_a) m_phase = 1;
    end else if (m_phase <= S_A) begin
      lo = 1 + (m_phase - 1) * L_A;
      hi = (lo + L_A - 1 > NR_A - 1) ? NR_A - 1 : lo + L_A - 1;
      for (int r = lo; r <= hi; r++) m_mem[r] = '0;
      m_phase++;
    end else begin
      m_phase = 0;
    end
    for (int r = 1; r < NR_A; r++) if (ers_a[r]) m_mem[r] = '0;
  endtask

  task automatic check_a();
    #1;
    chk("a_busy",  32'(busy_a),  32'(m_phase != 0));
    chk("a_ready", 32'(ready_a), 32'(m_phase == 0));
    chk("a_done",  32'(done_a),  32'(m_phase == S_A + 1));
    chk("a_rd0", rdata_a[31:0],  m_mem[raddr_a[4:0]]);
    chk("a_rd1", rdata_a[63:32], m_mem[raddr_a[9:5]]);
  endtask

  task automatic edge_a();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step_a();
    check_a();
    edge_a();
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        bw;
    logic [31:0] ers;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int busy_cnt, done_at, ready_bad, done_cnt;

    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0,  5'd5, 5'd5, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,  5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0,  5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,  5'd0, 5'd0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 5'd7, 32'h11111111, 1'b0, 32'h0,  5'd7, 5'd5, 32'h0,        32'hDEADBEEF};
    tbl[5]  = '{1'b1, 5'd7, 32'h12345678, 1'b1, 32'h0,  5'd7, 5'd7, 32'h11111111, 32'h11111111};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,  5'd7, 5'd7, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 32'h0,  5'd3, 5'd7, 32'h0,        32'h0};
    tbl[8]  = '{1'b1, 5'd3, 32'hFFFFFFFF, 1'b0, 32'h8,  5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,  5'd3, 5'd5, 32'h0,        32'hDEADBEEF};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h21, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,  5'd5, 5'd0, 32'h0,        32'h0};
    tbl[12] = '{1'b1, 5'd5, 32'h600DF00D, 1'b0, 32'h20, 5'd5, 5'd5, 32'h0,        32'h0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 32'h0,  5'd5, 5'd5, 32'h0,        32'h0};

    rst_n = 1'b0;
    ers_a = '0; bw_a = 0; req_a = 0; we_a = 0; waddr_a = '0; wdata_a = '0; raddr_a = {5'd0, 5'd5};
    ers_b = '0; bw_b = 0; req_b = 0; we_b = 0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_rd5",   rdata_a[63:32], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      we_a = tbl[i].we; waddr_a = tbl[i].waddr; wdata_a = tbl[i].wdata;
      bw_a = tbl[i].bw; ers_a = tbl[i].ers; raddr_a = {tbl[i].ra1, tbl[i].ra0};
      check_a();
      chk($sformatf("tbl%0d_p0", i), rdata_a[31:0],  tbl[i].e0);
      chk($sformatf("tbl%0d_p1", i), rdata_a[63:32], tbl[i].e1);
      edge_a();
    end
    we_a = 0; bw_a = 0; ers_a = '0;

    // Full scrub at defaults: load every register non-zero first
    for (int r = 1; r < NR_A; r++) begin
      we_a = 1; waddr_a = 5'(r); wdata_a = 32'hC0DE0000 | 32'(r);
      step_a();
    end
    we_a = 0;
    req_a = 1;
    step_a();
    req_a = 0;
    busy_cnt = 0; done_at = 0; ready_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      raddr_a = (c == 10) ? {5'd10, 5'd9} : {5'd31, 5'd1};
      // Writes presented during the scrub must be dropped.
      we_a = 1; waddr_a = 5'd20; wdata_a = 32'h5555AAAA;
      check_a();
      if (busy_a) busy_cnt++;
      if (busy_a && ready_a) ready_bad++;
      if (done_a) done_at = c;
      if (c == 10) begin
        chk("scrub_r9_wiped", rdata_a[31:0],  32'h0);
        chk("scrub_r10_old",  rdata_a[63:32], 32'hC0DE000A);
      end
      if (!busy_a) we_a = 0;
      edge_a();
      we_a = 0;
    end
    chk("scrub_busy_cycles", 32'(busy_cnt),  32'd32);
    chk("scrub_done_cycle",  32'(done_at),   32'd32);
    chk("scrub_ready_low",   32'(ready_bad), 32'd0);
    for (int r = 0; r < NR_A; r++) begin
      raddr_a = {5'(r), 5'(r)};
      #1;
      chk($sformatf("post_scrub_r%0d", r), rdata_a[31:0], 32'h0);
    end

    // Reset in the middle of a scrub
    we_a = 1; waddr_a = 5'd31; wdata_a = 32'h31313131;
    step_a();
    we_a = 0; req_a = 1;
    step_a();
    req_a = 0;
    for (int c = 0; c < 5; c++) step_a();
    raddr_a = {5'd31, 5'd31};
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(busy_a),  32'd0);
    chk("abort_ready", 32'(ready_a), 32'd1);
    chk("abort_done",  32'(done_a),  32'd0);
    chk("abort_r31",   rdata_a[31:0], 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      check_a();
      if (done_a) done_cnt++;
      edge_a();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Randomized stimulus against the model
    for (int c = 0; c < 800; c++) begin
      we_a    = 1'($urandom_range(0, 1));
      waddr_a = 5'($urandom_range(0, 31));
      wdata_a = $urandom;
      bw_a    = ($urandom_range(0, 7) == 0);
      ers_a   = ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      req_a   = ($urandom_range(0, 39) == 0);
      raddr_a = 10'($urandom_range(0, 1023));
      step_a();
    end
    we_a = 0; ers_a = '0; req_a = 0; bw_a = 0;

    // Instance B: 16 registers, 4 lanes, 3 read ports
    for (int r = 1; r < 16; r++) begin
      we_b = 1; waddr_b = 4'(r); wdata_b = 32'hB0000000 | 32'(r);
      @(posedge clk); @(negedge clk);
    end
    we_b = 0;
    raddr_b = {4'd0, 4'd1, 4'd15};
    #1;
    chk("b_load_r15", rdata_b[31:0],  32'hB000000F);
    chk("b_load_r1",  rdata_b[63:32], 32'hB0000001);
    req_b = 1;
    #1;
    chk("b_idle_busy", 32'(busy_b), 32'd0);
    @(posedge clk); @(negedge clk);
    // req held: SCRUB c=1..4, DONE c=5, IDLE c=6, second scrub from c=7
    for (int c = 1; c <= 8; c++) begin
      if (c >= 2 && c <= 4)
        raddr_b = {4'(4 * (c - 1) - 1), 4'(4 * (c - 1) + 1), 4'(4 * (c - 1))};
      else if (c == 5)
        raddr_b = {4'd14, 4'd13, 4'd15};
      else
        raddr_b = {4'd0, 4'd0, 4'd0};
      #1;
      chk($sformatf("b_busy_c%0d", c),  32'(busy_b),  32'((c <= 5) || (c >= 7)));
      chk($sformatf("b_ready_c%0d", c), 32'(ready_b), 32'(c == 6));
      chk($sformatf("b_done_c%0d", c),  32'(done_b),  32'(c == 5));
      if (c >= 2 && c <= 4) begin
        chk($sformatf("b_wiped_c%0d", c), rdata_b[31:0],  32'h0);
        chk($sformatf("b_old_c%0d", c),   rdata_b[63:32], 32'hB0000000 | 32'(4 * (c - 1) + 1));
        chk($sformatf("b_wp2_c%0d", c),   rdata_b[95:64], 32'h0);
      end
      if (c == 5) begin
        chk("b_r15_wiped", rdata_b[31:0],  32'h0);
        chk("b_r13_wiped", rdata_b[63:32], 32'h0);
        chk("b_r14_wiped", rdata_b[95:64], 32'h0);
      end
      @(posedge clk); @(negedge clk);
    end
    req_b = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
